// File: rtl/arb_rr8.sv
// ---------------------------------------------------------------------------
// arb_rr8 -- eight-way round-robin arbiter with bounded hold time
//
// A single resource is handed to one of eight requesters at a time. Winners
// are picked round-robin, starting just after the most recently served
// requester. A grant ends when its holder drops the request, when
// arbitration is disabled, or when the holder has had it for MAX_HOLD
// cycles. Every grant is followed by at least one idle cycle. The granted
// index is also shown on an active-low 7-segment display.
//
// Parameters:
//   MAX_HOLD  longest continuous grant in cycles (1..255)
//
// Ports:
//   clk     sole clock, rising-edge
//   rst_n   asynchronous active-low reset
//   en      arbitration enable; low blocks new grants and revokes the
//           current grant
//   req     request lines, one per requester
//   gnt     registered one-hot grant (zero when idle)
//   gnt_id  registered binary index of the grant holder (zero when idle)
//   valid   registered, high exactly when gnt is non-zero
//   pend    registered OR of req sampled on the previous edge
//   led     registered active-low segments g..a (led[6] = g)
// ---------------------------------------------------------------------------
module arb_rr8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       valid,
  output logic       pend,
  output logic [6:0] led
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [6:0] LED_DASH   = 7'b0111111;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       valid_q, valid_d;
  logic       pend_q, pend_d;
  logic [6:0] led_q, led_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] last_id_q, last_id_d;

  logic [2:0] rr_id;
  logic       rr_found;

  function automatic logic [6:0] seg_pattern(input logic [2:0] value);
    logic [6:0] pattern;
    case (value)
      3'd0:    pattern = 7'b1000000;
      3'd1:    pattern = 7'b1111001;
      3'd2:    pattern = 7'b0100100;
      3'd3:    pattern = 7'b0110000;
      3'd4:    pattern = 7'b0011001;
      3'd5:    pattern = 7'b0010010;
      3'd6:    pattern = 7'b0000010;
      default: pattern = 7'b1111000;
    endcase
    return pattern;
  endfunction

  // Round-robin search: walk last_id+1, last_id+2, ... (mod 8) and take the
  // first requesting index. The eighth step lands on last_id itself, so a
  // lone requester that was just served can still win.
  always_comb begin
    rr_id    = 3'd0;
    rr_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!rr_found && req[3'(last_id_q + 3'(k))]) begin
        rr_found = 1'b1;
        rr_id    = 3'(last_id_q + 3'(k));
      end
    end
  end

  // Next-state and output logic. Because the GRANT exit always lands in
  // IDLE, the mandatory idle cycle between grants falls out naturally.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    last_id_d = last_id_q;
    pend_d    = |req;

    case (state_q)
      IDLE: begin
        if (en && rr_found) begin
          state_d  = GRANT;
          gnt_d    = 8'b1 << rr_id;
          gnt_id_d = rr_id;
          valid_d  = 1'b1;
          hold_d   = 8'd1;
        end else begin
          gnt_d    = 8'd0;
          gnt_id_d = 3'd0;
          valid_d  = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q] || !en || (hold_q == HOLD_LIMIT)) begin
          state_d   = IDLE;
          last_id_d = gnt_id_q;
          gnt_d     = 8'd0;
          gnt_id_d  = 3'd0;
          valid_d   = 1'b0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 8'd0;
        gnt_id_d = 3'd0;
        valid_d  = 1'b0;
      end
    endcase

    led_d = valid_d ? seg_pattern(gnt_id_d) : LED_DASH;
  end

  // last_id resets to 7 so the first search after reset begins at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 8'd0;
      gnt_id_q  <= 3'd0;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      led_q     <= LED_DASH;
      hold_q    <= 8'd0;
      last_id_q <= 3'd7;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      led_q     <= led_d;
      hold_q    <= hold_d;
      last_id_q <= last_id_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign valid  = valid_q;
  assign pend   = pend_q;
  assign led    = led_q;

endmodule

// File: tb/tb_arb_rr8.sv
// ---------------------------------------------------------------------------
// tb_arb_rr8 -- self-checking bench for arb_rr8
//
// A reference model samples req/en on each rising edge and queues the
// outputs the arbiter should show afterwards; a monitor pops and compares
// on each falling edge. Directed sequences cover the documented scenarios
// and are followed by a randomized run with occasional mid-run resets.
// ---------------------------------------------------------------------------
module tb_arb_rr8;

  localparam int MH = 4;
  localparam logic [6:0] DASH = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       valid;
  logic       pend;
  logic [6:0] led;

  arb_rr8 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .valid (valid),
    .pend  (pend),
    .led   (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       pend;
    logic [6:0] led;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Reference state: holder index (-1 when nobody holds), cycles held so
  // far, and the most recently served requester.
  int cur = -1;
  int held = 0;
  int last = 7;

  function automatic logic [6:0] ledOf(input int id);
    case (id)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      default: return DASH;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the arbitration rules to what is sampled on
  // each edge and pushes the outputs expected after that edge.
  initial begin
    exp_t e;
    int   ridx;
    bit   found;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur  = -1;
        held = 0;
        last = 7;
        sb.delete();
      end else begin
        if (cur < 0) begin
          if (en && (req != 8'd0)) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
              ridx = (last + k) % 8;
              if (!found && req[ridx]) begin
                found = 1'b1;
                cur   = ridx;
              end
            end
            held = 1;
          end
        end else if (!req[cur] || !en || (held == MH)) begin
          last = cur;
          cur  = -1;
        end else begin
          held++;
        end
        e.gnt   = (cur >= 0) ? 8'(1 << cur) : 8'd0;
        e.id    = (cur >= 0) ? 3'(cur) : 3'd0;
        e.valid = (cur >= 0);
        e.pend  = |req;
        e.led   = (cur >= 0) ? ledOf(cur) : DASH;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares every registered output against the queued
  // expectation, plus the structural invariants of the grant vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (sb.size() > 0)) begin
        e = sb.pop_front();
        checkOutput("sb_gnt", 32'(gnt), 32'(e.gnt));
        checkOutput("sb_gnt_id", 32'(gnt_id), 32'(e.id));
        checkOutput("sb_valid", 32'(valid), 32'(e.valid));
        checkOutput("sb_pend", 32'(pend), 32'(e.pend));
        checkOutput("sb_led", 32'(led), 32'(e.led));
        checkOutput("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
        checkOutput("valid_eq_or_gnt", 32'(valid), 32'(|gnt));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic e);
    @(negedge clk);
    #1;
    req = r;
    en  = e;
  endtask

  // Asserts reset between edges, verifies the outputs clear without any
  // clock edge, then releases reset just after a falling edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_gnt_id", 32'(gnt_id), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_pend", 32'(pend), 32'd0);
    checkOutput("rst_led", 32'(led), 32'(DASH));
    req = 8'd0;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    #3;

    // First grant after reset searches from 0, then wraps to 7.
    doReset();
    applyStimulus(8'h81, 1'b1);
    afterEdge();
    checkOutput("d1_first_id", 32'(gnt_id), 32'd0);
    checkOutput("d1_first_led", 32'(led), 32'(7'b1000000));
    applyStimulus(8'h80, 1'b1);
    afterEdge();
    checkOutput("d1_idle_valid", 32'(valid), 32'd0);
    checkOutput("d1_idle_led", 32'(led), 32'(DASH));
    afterEdge();
    checkOutput("d1_second_id", 32'(gnt_id), 32'd7);
    checkOutput("d1_second_led", 32'(led), 32'(7'b1111000));

    // All requesting: rotate through 0..7 and back to 0, MH cycles each.
    doReset();
    applyStimulus(8'hFF, 1'b1);
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c <= MH; c++) begin
        afterEdge();
        if (c < MH) begin
          checkOutput("rot_id", 32'(gnt_id), 32'(g % 8));
          checkOutput("rot_valid", 32'(valid), 32'd1);
        end else begin
          checkOutput("rot_gap_led", 32'(led), 32'(DASH));
        end
      end
    end

    // Single requester: MH cycles granted, one idle, repeating.
    doReset();
    applyStimulus(8'h04, 1'b1);
    for (int c = 0; c < 3 * (MH + 1); c++) begin
      afterEdge();
      checkOutput("hold_valid", 32'(valid), 32'((c % (MH + 1)) != MH));
      if ((c % (MH + 1)) != MH) checkOutput("hold_id", 32'(gnt_id), 32'd2);
    end

    // en dropped for one cycle revokes grant 5; next search wraps to 1.
    doReset();
    applyStimulus(8'h20, 1'b1);
    afterEdge();
    checkOutput("en_grant5", 32'(gnt_id), 32'd5);
    applyStimulus(8'h20, 1'b0);
    afterEdge();
    checkOutput("en_revoke", 32'(valid), 32'd0);
    applyStimulus(8'h22, 1'b1);
    afterEdge();
    checkOutput("en_wrap_id", 32'(gnt_id), 32'd1);

    // Reset in the middle of grant 3; search restarts from 0 afterwards.
    doReset();
    applyStimulus(8'h08, 1'b1);
    afterEdge();
    checkOutput("mid_grant3", 32'(gnt_id), 32'd3);
    doReset();
    applyStimulus(8'h88, 1'b1);
    afterEdge();
    checkOutput("mid_after_id", 32'(gnt_id), 32'd3);
    checkOutput("mid_after_valid", 32'(valid), 32'd1);

    // Randomized traffic checked only through the scoreboard.
    doReset();
    r = 8'd0;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = r;
        2: r = 8'd1 << $urandom_range(0, 7);
        default: r = r ^ (8'd1 << $urandom_range(0, 7));
      endcase
      e = ($urandom_range(0, 9) != 0);
      applyStimulus(r, e);
      if ($urandom_range(0, 199) == 0) doReset();
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/arb_rr8.md
ARB_RR8 -- requirements
Module: arb_rr8

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  arbitration enable; 0 blocks new grants and revokes any current grant.
REQ-005 req  input  8  request lines; req[i]=1 means requester i wants the resource.
REQ-006 gnt  output  8  one-hot grant, registered; all-zero when no grant.
REQ-007 gnt_id  output  3  binary index of granted requester, registered; 0 when no grant.
REQ-008 valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-009 pend  output  1  registered; OR of req sampled on the previous edge.
REQ-010 led  output  7  active-low 7-segment pattern of the display value, registered, bit order g..a (led[6]=g).

Function
REQ-011 The block SHALL implement two states: IDLE (no grant) and GRANT (one requester granted).
REQ-012 In IDLE, on a rising edge with en=1 and req non-zero, the block SHALL enter GRANT and grant the winner, visible on gnt/gnt_id/valid after that same edge (latency 1 cycle from sampled request).
REQ-013 Winner selection SHALL be round-robin: search indices last_id+1, last_id+2, ... modulo 8, first index with req set wins.
REQ-014 last_id SHALL be an internal 3-bit register updated to gnt_id when a grant ends; wrap from 7 to 0 is modulo-8.
REQ-015 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with gnt=0, gnt_id=0, valid=0.
REQ-016 An internal hold counter SHALL load 1 on entering GRANT and increment by 1 each cycle GRANT is retained.
REQ-017 In GRANT, the grant SHALL end on the edge where any of: req[gnt_id]=0, en=0, or hold counter = MAX_HOLD; the block then enters IDLE and clears gnt, gnt_id, valid.
REQ-018 A grant SHALL therefore last at most MAX_HOLD cycles; with MAX_HOLD=1 every grant lasts exactly 1 cycle.
REQ-019 After a grant ends, at least one IDLE cycle (valid=0) SHALL occur before the next grant, including when requests remain pending.
REQ-020 Requests from non-granted requesters during GRANT SHALL NOT affect the current grant.
REQ-021 A requester whose grant ended by timeout and still requests SHALL have lowest priority in the next arbitration (consequence of REQ-013/014).
REQ-022 gnt SHALL never have more than one bit set; gnt[gnt_id]=1 whenever valid=1.
REQ-023 Display value SHALL be gnt_id when valid=1; led patterns for 0..7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
REQ-024 When valid=0, led SHALL be 0111111 (dash, segment g only lit).
REQ-025 led and pend SHALL update on the same edge as gnt so all outputs are cycle-aligned.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE, gnt=0, gnt_id=0, valid=0, pend=0, led=0111111, hold counter=0, last_id=7, independent of clk.
REQ-027 Reset asserted during GRANT SHALL revoke the grant immediately (asynchronously) without updating last_id beyond the reset value.
REQ-028 After rst_n deasserts, the first arbitration SHALL start its search at index 0.

Verification
REQ-029 Reset then req=8'b1000_0001, en=1 held -> first grant gnt_id=0 (led=1000000), after release by req[0]=0 next grant gnt_id=7 (led=1111000) following one IDLE cycle.
REQ-030 req=8'hFF held constantly, en=1, MAX_HOLD=16 -> grants to 0,1,...,7,0 each exactly 16 cycles, separated by one IDLE cycle with led=0111111.
REQ-031 Single requester req=8'b0000_0100 held, MAX_HOLD=4 -> valid pattern 4 high, 1 low repeating, gnt_id=2 each time.
REQ-032 Grant active on id 5, en driven 0 for one cycle -> grant cleared on that edge, last_id=5; en back to 1 with req=8'b0010_0010 -> next grant id 1... search from 6 wraps, grant id 1.
REQ-033 rst_n pulsed low mid-grant (id 3) without clock edge -> outputs go to reset values immediately; after release with req=8'b0000_1000 grant id 3 one edge later.
REQ-034 Every cycle: check gnt one-hot-or-zero, valid==|gnt, pend equals previous-edge |req, led matches REQ-023/024.
